adder_sched: RTL and testbench

ADDER_SCHED -- requirements
Module: adder_sched

---
 rtl/adder_sched.sv | 112 +++++++++++
 tb/tb_adder_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sched.sv
// Arbitrates four requesters onto one shared combinational adder; one add in flight at a time.
// Define ADDER_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module adder_sched #(
  parameter int unsigned NBIT = 8,
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*NBIT-1:0] req_a,
  input  logic [NREQ*NBIT-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NBIT-1:0]      add_a,
  output logic [NBIT-1:0]      add_b,
  input  logic [NBIT-1:0]      add_s,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_id,
  output logic [NBIT-1:0]      rsp_s,
  input  logic                 rsp_ready
);

  typedef enum logic [1:0] {StIdle, StAdd, StResp} state_e;

  state_e          state_q;
  logic            run_q;
  logic [1:0]      gnt_idx;
  logic            gnt_any;
  logic [NBIT-1:0] sel_a;
  logic [NBIT-1:0] sel_b;

  assign gnt_any = |req_valid;

`ifdef ADDER_RR_EN
  logic [1:0] ptr_q;

  // Scan from the highest offset down so the first valid requester after ptr_q wins.
  always_comb begin
    gnt_idx = ptr_q;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) gnt_idx = ptr_q + 2'(k);
    end
  end
`else
  always_comb begin
    gnt_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_valid[k]) gnt_idx = 2'(k);
    end
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_a = req_a[i*NBIT +: NBIT];
        sel_b = req_b[i*NBIT +: NBIT];
      end
    end
  end

  // The accept strobe is shown during the IDLE cycle itself so that acceptance and operand
  // capture happen on the same edge; run_q keeps it low in reset and until the first edge.
  always_comb begin
    req_ready = '0;
    if (run_q && (state_q == StIdle) && gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      run_q     <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      rsp_s     <= '0;
      rsp_valid <= 1'b0;
`ifdef ADDER_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      run_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (run_q && gnt_any) begin
            add_a   <= sel_a;
            add_b   <= sel_b;
            rsp_id  <= gnt_idx;
            state_q <= StAdd;
`ifdef ADDER_RR_EN
            ptr_q   <= gnt_idx + 2'd1;
`endif
          end
        end
        StAdd: begin
          rsp_s     <= add_s;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_sched.sv
// Randomized self-checking bench for adder_sched; a requester-level model predicts grants and sums.
module tb_adder_sched;

  localparam int NB = 8;
`ifdef ADDER_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [31:0]   req_a;
  logic [31:0]   req_b;
  logic [3:0]    req_ready;
  logic [NB-1:0] add_a;
  logic [NB-1:0] add_b;
  logic [NB-1:0] add_s;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [NB-1:0] rsp_s;
  logic          rsp_ready;

  int checks;
  int failures;

  // Requester-side state: which requesters are pending and the operands each one is holding.
  logic [3:0]    pend;
  logic [NB-1:0] pa [4];
  logic [NB-1:0] pb [4];
  int            ptr_m;

  assign add_s = add_a + add_b;

  adder_sched #(.NBIT(NB), .NREQ(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_s    (add_s),
    .rsp_valid(rsp_valid),
    .rsp_id   (rsp_id),
    .rsp_s    (rsp_s),
    .rsp_ready(rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] onehot(input int w);
    return (w < 0) ? 32'd0 : (32'd1 << w);
  endfunction

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < 4; i++) begin
      req_a[i*NB +: NB] = pa[i];
      req_b[i*NB +: NB] = pb[i];
    end
  endtask

  // Starts on a falling edge with the DUT idle; returns on a falling edge with it idle again.
  task automatic run_txn(input int stalls, input bit hold, output int w);
    logic [NB-1:0] s;
    drive();
    #1;
    w = pick(pend, ptr_m);
    chk("grant", {28'd0, req_ready}, onehot(w));
    @(posedge clk);
    @(negedge clk);
    s = NB'((int'(pa[w]) + int'(pb[w])) % 256);
    if (RrEn) ptr_m = (w + 1) % 4;
    chk("add_ready", {28'd0, req_ready}, 32'd0);
    chk("add_valid", {31'd0, rsp_valid}, 32'd0);
    if (!hold) begin
      pend[w] = 1'b0;
      pa[w] = NB'($urandom);
      pb[w] = NB'($urandom);
    end
    drive();
    @(posedge clk);
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_id", {30'd0, rsp_id}, 32'(w));
    chk("rsp_s", {24'd0, rsp_s}, {24'd0, s});
    chk("rsp_ready_zero", {28'd0, req_ready}, 32'd0);
    if (stalls > 0) rsp_ready = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_id", {30'd0, rsp_id}, 32'(w));
      chk("bp_s", {24'd0, rsp_s}, {24'd0, s});
      chk("bp_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("back_idle", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int w;
    checks    = 0;
    failures  = 0;
    ptr_m     = 0;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    pend      = 4'h0;
    for (int i = 0; i < 4; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    drive();
    req_valid = 4'hf;
    #12;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_add_a", {24'd0, add_a}, 32'd0);
    chk("rst_add_b", {24'd0, add_b}, 32'd0);
    chk("rst_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_s", {24'd0, rsp_s}, 32'd0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_no_req", {28'd0, req_ready}, 32'd0);
    @(negedge clk);

    // Contention: all four held high, response accepted immediately.
    pend = 4'hf;
    for (int i = 0; i < 4; i++) begin
      pa[i] = NB'($urandom);
      pb[i] = NB'($urandom);
    end
    for (int n = 0; n < 5; n++) run_txn(0, 1'b1, w);

    pend  = 4'b0010;
    pa[1] = 8'd1;
    pb[1] = 8'd2;
    run_txn(0, 1'b0, w);

    pend  = 4'b0001;
    pa[0] = 8'd200;
    pb[0] = 8'd100;
    run_txn(0, 1'b0, w);

    // Backpressure while another requester waits.
    pend  = 4'b0101;
    pa[0] = 8'd17;
    pb[0] = 8'd9;
    pa[2] = 8'd250;
    pb[2] = 8'd7;
    run_txn(5, 1'b0, w);
    run_txn(0, 1'b0, w);

    // Reset while the add is in flight.
    pend  = 4'b0100;
    pa[2] = 8'h5a;
    pb[2] = 8'ha5;
    drive();
    #1;
    w = pick(pend, ptr_m);
    chk("pre_rst_grant", {28'd0, req_ready}, onehot(w));
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_add_a", {24'd0, add_a}, 32'h5a);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_add_a", {24'd0, add_a}, 32'd0);
    chk("mid_rst_add_b", {24'd0, add_b}, 32'd0);
    #2;
    rst_n = 1'b1;
    ptr_m = 0;
    pend  = 4'h0;
    drive();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("dropped_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    pend = 4'hf;
    for (int i = 0; i < 4; i++) begin
      pa[i] = NB'($urandom);
      pb[i] = NB'($urandom);
    end
    run_txn(0, 1'b0, w);

    // Randomized traffic with pending requesters held until granted.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 4'h0;
        #1;
        chk("rand_idle", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pa[i] = NB'($urandom);
          pb[i] = NB'($urandom);
        end
      end
      if (pend == 4'h0) pend[$urandom_range(0, 3)] = 1'b1;
      run_txn(int'($urandom_range(0, 2)), 1'b0, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
